// File: rtl/lcd_timing_pattern_gen.sv
// Parametrised RGB565 LCD timing generator with bar/grid/ramp/solid test patterns.
// Optional build macro LCD_PATTERN_SCROLL_EN scrolls modes 0-2 horizontally by one pixel per frame.
module lcd_timing_pattern_gen #(
  parameter int unsigned H_ACTIVE     = 800,
  parameter int unsigned H_PULSE      = 1,
  parameter int unsigned H_BP         = 46,
  parameter int unsigned H_FP         = 210,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_PULSE      = 1,
  parameter int unsigned V_BP         = 23,
  parameter int unsigned V_FP         = 22,
  parameter bit          HS_POL       = 1'b0,
  parameter bit          VS_POL       = 1'b0,
  parameter int unsigned GRID_LOG2    = 5,
  parameter logic [15:0] SOLID_RGB565 = 16'hF800
) (
  input  logic        PixelClk,
  input  logic        Reset,
  input  logic        Enable,
  input  logic [1:0]  Mode,
  output logic        LCD_DE,
  output logic        LCD_HSYNC,
  output logic        LCD_VSYNC,
  output logic [4:0]  LCD_R,
  output logic [5:0]  LCD_G,
  output logic [4:0]  LCD_B,
  output logic        Frame_Start,
  output logic [10:0] Pix_X,
  output logic [10:0] Pix_Y
);

  localparam int unsigned H_TOTAL     = H_PULSE + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL     = V_PULSE + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HW          = $clog2(H_TOTAL + 1);
  localparam int unsigned VW          = $clog2(V_TOTAL + 1);
  localparam int unsigned H_ACT_START = H_PULSE + H_BP;
  localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int unsigned V_ACT_START = V_PULSE + V_BP;
  localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;
  localparam int unsigned BAR_W       = H_ACTIVE / 8;

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [1:0]    r_mode_q;

  logic          w_h_last;
  logic          w_v_last;
  logic          w_origin;
  logic          w_active;
  logic          w_de;
  logic [10:0]   w_x;
  logic [10:0]   w_y;
  logic [10:0]   w_x_eff;
  logic [10:0]   w_bar_idx;
  logic [2:0]    w_bar;
  logic [15:0]   w_lvl_full;
  logic [4:0]    w_lvl;
  logic [15:0]   w_rgb;

  assign w_h_last = (r_h_cnt == HW'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == VW'(V_TOTAL - 1));
  assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_active = (r_h_cnt >= HW'(H_ACT_START)) && (r_h_cnt < HW'(H_ACT_END)) &&
                    (r_v_cnt >= VW'(V_ACT_START)) && (r_v_cnt < VW'(V_ACT_END));
  assign w_de     = w_active && Enable;
  assign w_x      = 11'(r_h_cnt - HW'(H_ACT_START));
  assign w_y      = 11'(r_v_cnt - VW'(V_ACT_START));

  // Free-running raster counters; they never pause for Enable
  always_ff @(posedge PixelClk) begin
    if (Reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  // Pattern mode only changes on a frame boundary
  always_ff @(posedge PixelClk) begin
    if (Reset) begin
      r_mode_q <= 2'd0;
    end else if (w_origin) begin
      r_mode_q <= Mode;
    end
  end

`ifdef LCD_PATTERN_SCROLL_EN
  logic [10:0] r_offset;
  logic [11:0] w_x_sum;

  // Offset steps as the counters roll into a new frame, so frame n uses offset n
  always_ff @(posedge PixelClk) begin
    if (Reset) begin
      r_offset <= '0;
    end else if (w_h_last && w_v_last) begin
      r_offset <= (r_offset == 11'(H_ACTIVE - 1)) ? 11'd0 : r_offset + 11'd1;
    end
  end

  assign w_x_sum = {1'b0, w_x} + {1'b0, r_offset};
  assign w_x_eff = (w_x_sum >= 12'(H_ACTIVE)) ? 11'(w_x_sum - 12'(H_ACTIVE)) : w_x_sum[10:0];
`else
  assign w_x_eff = w_x;
`endif

  assign w_bar_idx  = w_x_eff / 11'(BAR_W);
  assign w_bar      = (w_bar_idx > 11'd7) ? 3'd7 : w_bar_idx[2:0];
  assign w_lvl_full = {w_x_eff, 5'b0} / 16'(H_ACTIVE);
  assign w_lvl      = (w_lvl_full > 16'd31) ? 5'd31 : w_lvl_full[4:0];

  always_comb begin
    w_rgb = 16'h0000;
    case (r_mode_q)
      2'd0: begin
        case (w_bar)
          3'd0:    w_rgb = 16'hFFFF;
          3'd1:    w_rgb = 16'hFFE0;
          3'd2:    w_rgb = 16'h07FF;
          3'd3:    w_rgb = 16'h07E0;
          3'd4:    w_rgb = 16'hF81F;
          3'd5:    w_rgb = 16'hF800;
          3'd6:    w_rgb = 16'h001F;
          default: w_rgb = 16'h0000;
        endcase
      end
      2'd1: begin
        if ((w_x_eff[GRID_LOG2-1:0] == '0) || (w_y[GRID_LOG2-1:0] == '0)) begin
          w_rgb = 16'hFFFF;
        end
      end
      2'd2:    w_rgb = {w_lvl, w_lvl, w_lvl[4], w_lvl};
      default: w_rgb = SOLID_RGB565;
    endcase
  end

  // Output stage: everything leaves one clock after the counter state it describes
  always_ff @(posedge PixelClk) begin
    if (Reset) begin
      LCD_DE      <= 1'b0;
      LCD_HSYNC   <= ~HS_POL;
      LCD_VSYNC   <= ~VS_POL;
      LCD_R       <= '0;
      LCD_G       <= '0;
      LCD_B       <= '0;
      Frame_Start <= 1'b0;
      Pix_X       <= '0;
      Pix_Y       <= '0;
    end else begin
      LCD_DE      <= w_de;
      LCD_HSYNC   <= (r_h_cnt < HW'(H_PULSE)) ? HS_POL : ~HS_POL;
      LCD_VSYNC   <= (r_v_cnt < VW'(V_PULSE)) ? VS_POL : ~VS_POL;
      LCD_R       <= w_de ? w_rgb[15:11] : 5'd0;
      LCD_G       <= w_de ? w_rgb[10:5]  : 6'd0;
      LCD_B       <= w_de ? w_rgb[4:0]   : 5'd0;
      Frame_Start <= w_origin;
      Pix_X       <= w_de ? w_x : 11'd0;
      Pix_Y       <= w_de ? w_y : 11'd0;
    end
  end

endmodule
